// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: streams LSW-first operand pairs through one 32-bit adder, chaining carry/borrow per word.
// One-cycle result latency, single output register (in_ready drops while a result is stalled); ADD_SEQ_OVF_EN enables ovf.
module add_seq_ctrl #(
  parameter int MAX_WORDS = 8,
  localparam int CW = $clog2(MAX_WORDS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [CW-1:0] num_words,
  input  logic          sub,
  input  logic          cin_init,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_sum,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          carry_out,
  output logic          ovf
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          op_q, op_d;
  logic          carry_q, carry_d;
  logic          out_vld_q, out_vld_d;
  logic          out_last_q, out_last_d;
  logic [31:0]   out_sum_q, out_sum_d;
  logic          carry_out_q, carry_out_d;

  logic [31:0]   b_eff;
  logic [32:0]   sum_w;
  logic          in_hs;
  logic          out_hs;
  logic          last_beat;

  // Subtraction runs as A + ~B + carry, with the borrow-in folded into the initial carry.
  assign b_eff     = op_q ? ~in_b : in_b;
  assign sum_w     = {1'b0, in_a} + {1'b0, b_eff} + {32'd0, carry_q};
  assign in_ready  = (state_q == S_RUN) && (!out_vld_q || out_ready);
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_vld_q && out_ready;
  assign last_beat = (cnt_q == len_q - CW'(1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    carry_d     = carry_q;
    out_vld_d   = out_vld_q;
    out_last_d  = out_last_q;
    out_sum_d   = out_sum_q;
    carry_out_d = carry_out_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            len_d       = num_words;
            op_d        = sub;
            carry_d     = cin_init ^ sub;
            cnt_d       = '0;
            carry_out_d = 1'b0;
            state_d     = S_RUN;
          end else begin
            carry_out_d = cin_init;
            state_d     = S_FIN;
          end
        end
      end
      S_RUN: begin
        if (in_hs) begin
          out_sum_d  = sum_w[31:0];
          out_vld_d  = 1'b1;
          out_last_d = last_beat;
          carry_d    = sum_w[32];
          cnt_d      = cnt_q + CW'(1);
          if (last_beat) state_d = S_DRAIN;
        end else if (out_hs) begin
          out_vld_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (out_hs) begin
          out_vld_d   = 1'b0;
          out_last_d  = 1'b0;
          carry_out_d = op_q ? ~carry_q : carry_q;
          state_d     = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      op_q        <= 1'b0;
      carry_q     <= 1'b0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_sum_q   <= '0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      carry_q     <= carry_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
      out_sum_q   <= out_sum_d;
      carry_out_q <= carry_out_d;
    end
  end

`ifdef ADD_SEQ_OVF_EN
  logic word_ovf_q, word_ovf_d;
  logic ovf_q, ovf_d;
  logic c31;

  // Carry into bit 31 recovered from the sum bit; overflow is carry-in xor carry-out of the MSB.
  assign c31 = in_a[31] ^ b_eff[31] ^ sum_w[31];

  always_comb begin
    word_ovf_d = word_ovf_q;
    ovf_d      = ovf_q;
    if (in_hs) word_ovf_d = sum_w[32] ^ c31;
    if (state_q == S_IDLE && start)        ovf_d = 1'b0;
    else if (state_q == S_DRAIN && out_hs) ovf_d = word_ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_ovf_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      word_ovf_q <= word_ovf_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign out_valid = out_vld_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign carry_out = carry_out_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl: directed cases plus randomized commands checked against wide-integer arithmetic.
module tb_add_seq_ctrl;
  localparam int MW = 8;
  localparam int CW = $clog2(MW + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic          sub = 1'b0;
  logic          cin_init = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_a = '0;
  logic [31:0]   in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_sum;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          carry_out;
  logic          ovf;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  add_seq_ctrl #(.MAX_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_words(num_words), .sub(sub),
    .cin_init(cin_init), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_last(out_last), .busy(busy), .done(done), .carry_out(carry_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_cmd(input int len, input logic op, input logic cin,
                         input logic [255:0] a, input logic [255:0] b, input bit rnd,
                         input int stall_at, input int stall_len, input bit poke);
    logic [256:0] m, wa, wb, wr;
    logic         exp_co, exp_ovf, sa, sb, sr;
    logic         hs_in, hs_out, prev_stall, stalled;
    logic [31:0]  prev_sum;
    int           cyc, wi, wo;

    m  = (257'd1 << (32 * len)) - 257'd1;
    wa = {1'b0, a} & m;
    wb = {1'b0, b} & m;
    if (!op) begin
      wr     = wa + wb + 257'(cin);
      exp_co = wr[32 * len];
    end else begin
      wr     = wa - wb - 257'(cin);
      exp_co = (wa < wb + 257'(cin));
    end
    wr = wr & m;
    sa = wa[32 * len - 1];
    sb = wb[32 * len - 1];
    sr = wr[32 * len - 1];
    exp_ovf = op ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
`ifndef ADD_SEQ_OVF_EN
    exp_ovf = 1'b0;
`endif

    start = 1'b1; num_words = CW'(len); sub = op; cin_init = cin;
    @(posedge clk); #1;
    start = 1'b0; sub = ~op; cin_init = ~cin; num_words = '0;
    chk1("busy_after_start", busy, 1'b1);
    chk1("ovf_clear_on_start", ovf, 1'b0);

    cyc = 0; wi = 0; wo = 0; prev_stall = 1'b0; prev_sum = '0;
    while (wo < len && cyc < 400) begin
      in_valid = (wi < len) && (!rnd || $urandom_range(0, 3) != 0);
      if (wi < len) begin
        in_a = a[32 * wi +: 32];
        in_b = b[32 * wi +: 32];
      end
      stalled   = (cyc >= stall_at) && (cyc < stall_at + stall_len);
      out_ready = !stalled && (!rnd || $urandom_range(0, 2) != 0);
      start     = poke && (cyc == 1);
      num_words = CW'(1);
      #1;
      hs_in  = in_valid && in_ready;
      hs_out = out_valid && out_ready;
      chk1("no_early_done", done, 1'b0);
      if (prev_stall) chk32("stall_sum_hold", out_sum, prev_sum);
      if (out_valid && !out_ready) chk1("stall_in_ready_low", in_ready, 1'b0);
      if (hs_out) begin
        chk32("result_word", out_sum, wr[32 * wo +: 32]);
        chk1("out_last", out_last, wo == len - 1);
        wo++;
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = out_sum;
      if (hs_in) wi++;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0; num_words = '0;
    chk32("words_received", wo, len);
    chk1("done_pulse", done, 1'b1);
    chk1("busy_in_fin", busy, 1'b1);
    chk1("out_valid_after_drain", out_valid, 1'b0);
    chk1("carry_out", carry_out, exp_co);
    chk1("ovf", ovf, exp_ovf);
    @(posedge clk); #1;
    chk1("done_one_cycle", done, 1'b0);
    chk1("idle_after_fin", busy, 1'b0);
    chk1("carry_out_held", carry_out, exp_co);
  endtask

  task automatic run_zero(input logic cin);
    start = 1'b1; num_words = '0; sub = 1'($urandom); cin_init = cin;
    @(posedge clk); #1;
    start = 1'b0;
    chk1("zero_done", done, 1'b1);
    chk1("zero_no_valid", out_valid, 1'b0);
    chk1("zero_carry_out", carry_out, cin);
    chk1("zero_ovf", ovf, 1'b0);
    chk1("zero_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    chk1("zero_done_clear", done, 1'b0);
    chk1("zero_idle", busy, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b0);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk32({tag, "_out_sum"}, out_sum, 32'd0);
    chk1({tag, "_out_last"}, out_last, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_carry_out"}, carry_out, 1'b0);
    chk1({tag, "_ovf"}, ovf, 1'b0);
  endtask

  initial begin
    logic [255:0] ra, rb;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_cmd(1, 1'b0, 1'b0, 256'hFFFFFFFF, 256'h1, 1'b0, 1000, 0, 1'b0);
    run_cmd(2, 1'b0, 1'b0, 256'h00000001_FFFFFFFF, 256'h1, 1'b0, 1000, 0, 1'b0);
    run_cmd(2, 1'b1, 1'b0, 256'h0, 256'h1, 1'b0, 1000, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      ra[32 * i +: 32] = $urandom;
      rb[32 * i +: 32] = $urandom;
    end
    run_cmd(4, 1'b0, 1'b0, ra, rb, 1'b0, 1, 5, 1'b0);
    run_zero(1'b1);
    run_zero(1'b0);
    run_cmd(3, 1'b0, 1'b1, ra, rb, 1'b0, 1000, 0, 1'b1);
    run_cmd(1, 1'b0, 1'b0, 256'h7FFFFFFF, 256'h1, 1'b0, 1000, 0, 1'b0);
    run_cmd(8, 1'b0, 1'b1, {256{1'b1}}, 256'h0, 1'b0, 1000, 0, 1'b0);
    run_cmd(8, 1'b1, 1'b1, 256'h0, 256'h0, 1'b0, 1000, 0, 1'b0);

    // Reset while a result word is stalled at the output.
    start = 1'b1; num_words = CW'(3); sub = 1'b0; cin_init = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_a = 32'd5; in_b = 32'd6; out_ready = 1'b0;
    @(posedge clk); #1;
    chk1("pre_reset_valid", out_valid, 1'b1);
    chk32("pre_reset_sum", out_sum, 32'd11);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk1("post_reset_no_valid", out_valid, 1'b0);
      chk1("post_reset_idle", busy, 1'b0);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    run_cmd(2, 1'b1, 1'b1, 256'h5_00000000, 256'h3_00000001, 1'b0, 1000, 0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 8; i++) begin
        ra[32 * i +: 32] = ($urandom_range(0, 4) == 0) ? 32'hFFFFFFFF : $urandom;
        rb[32 * i +: 32] = ($urandom_range(0, 4) == 0) ? 32'h00000000 : $urandom;
      end
      run_cmd(int'($urandom_range(1, MW)), 1'($urandom), 1'($urandom), ra, rb,
              1'b1, 1000, 0, 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
